// File: rtl/pdm_pkg.sv
// Shared PDM family definitions: PCM full-scale constants and 32-bit clip helper.
// Output format is offset-binary; PDM_MIDSCALE represents zero.
package pdm_pkg;

  localparam logic [31:0] PDM_MIDSCALE = 32'h8000_0000;
  localparam logic [31:0] PDM_FS_MAX   = 32'hFFFF_FFFF;
  localparam logic [31:0] PDM_FS_MIN   = 32'h0000_0000;

  // Clip a 34-bit signed offset-binary value into 0 .. 2^32-1.
  function automatic logic [31:0] sat32(input logic signed [33:0] v);
    if (v > 34'sh0_FFFF_FFFF)
      return PDM_FS_MAX;
    else if (v < 34'sh0)
      return PDM_FS_MIN;
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/pdm_edge_sync.sv
// Two-flop synchroniser with single-clk edge pulse.
// Ports: clk, rst (async high), async_i, edge_o (FALL=0 rise, FALL=1 fall).
module pdm_edge_sync #(
  parameter bit FALL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);

  logic d_q;
  logic dd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q  <= 1'b0;
      dd_q <= 1'b0;
    end else begin
      d_q  <= async_i;
      dd_q <= d_q;
    end
  end

  assign edge_o = FALL ? (~d_q & dd_q) : (d_q & ~dd_q);

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM -> PCM CIC (Hogenauer) decimator, ratio 2^LOG2_DECIM, ORDER stages.
// Ports: clk, rst, sdi, ock in; dout (offset-binary), dout_valid, sat out.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int ORDER      = 4,
  parameter int LOG2_DECIM = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdi,
  input  logic        ock,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        sat
);

  localparam int W  = ORDER * LOG2_DECIM + 2;
  localparam int SH = 31 - ORDER * LOG2_DECIM;

  logic tick;

  pdm_edge_sync #(.FALL(1'b0)) u_ock_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ock),
    .edge_o  (tick)
  );

  logic signed [W-1:0] x;
  logic signed [W-1:0] int_q  [ORDER];
  logic signed [W-1:0] int_in [ORDER];
  logic signed [W-1:0] dly_q  [ORDER];
  logic signed [W-1:0] cmb_in [ORDER];
  logic signed [W-1:0] cmb    [ORDER];
  logic signed [W-1:0] y_q;

  logic [LOG2_DECIM-1:0] cnt_q;
  logic                  str_q;
  logic                  y_vld_q;
  logic [31:0]           dout_q;
  logic                  dout_valid_q;
  logic                  sat_q;

  assign x = sdi ? W'(1) : '1;

  // Integrators wrap mod 2^W; each stage adds the previous stage's old value.
  for (genvar k = 0; k < ORDER; k++) begin : g_int
    if (k == 0) begin : g_first
      assign int_in[k] = x;
    end else begin : g_rest
      assign int_in[k] = int_q[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        int_q[k] <= '0;
      else if (tick)
        int_q[k] <= int_q[k] + int_in[k];
    end
  end

  // Combs run once per frame, the cycle after the strobe tick.
  for (genvar k = 0; k < ORDER; k++) begin : g_cmb
    if (k == 0) begin : g_first
      assign cmb_in[k] = int_q[ORDER-1];
    end else begin : g_rest
      assign cmb_in[k] = cmb[k-1];
    end

    assign cmb[k] = cmb_in[k] - dly_q[k];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        dly_q[k] <= '0;
      else if (str_q)
        dly_q[k] <= cmb_in[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      str_q <= 1'b0;
    end else begin
      str_q <= tick && (cnt_q == '1);
      if (tick)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      y_vld_q <= str_q;
      if (str_q)
        y_q <= cmb[ORDER-1];
    end
  end

  // W+SH = 33, so the scaled value plus offset fits 34 signed bits.
  logic signed [33:0] y_ext;
  logic signed [33:0] pcm;

  assign y_ext = 34'(y_q);
  assign pcm   = (y_ext <<< SH) + 34'sh0_8000_0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= PDM_MIDSCALE;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      dout_valid_q <= y_vld_q;
      sat_q        <= y_vld_q && (pcm > 34'sh0_FFFF_FFFF);
      if (y_vld_q)
        dout_q <= sat32(pcm);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator with output scoreboard.
// ock runs at clk/16; expected frames are queued as stimulus is driven.
module tb_pdm_cic_decimator;

  localparam int HALF = 8;
  localparam int R    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdi;
  logic        ock;
  logic [31:0] dout;
  logic        dout_valid;
  logic        sat;

  pdm_cic_decimator #(.ORDER(4), .LOG2_DECIM(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .sdi        (sdi),
    .ock        (ock),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] d;
    logic        s;
    logic [31:0] tol;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc    = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every dout_valid pops one queued frame.
  always begin
    @(posedge clk);
    #1;
    if (dout_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        logic [31:0] diff;
        e = sbq.pop_front();
        if (e.chk) begin
          diff = (dout > e.d) ? dout - e.d : e.d - dout;
          chk("dout_tol", 32'(diff <= e.tol), 32'd1);
          chk("sat", 32'(sat), 32'(e.s));
        end
      end
    end
  end

  function automatic logic gen_bit(input int mode, input int i);
    logic [32:0] s;
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return (i % 2 == 0);
      default: begin
        s   = {1'b0, acc} + {1'b0, 32'hC000_0000};
        acc = s[31:0];
        return s[32];
      end
    endcase
  endfunction

  task automatic tick(input logic b);
    @(negedge clk);
    sdi = b;
    ock = 1'b1;
    repeat (HALF) @(negedge clk);
    ock = 1'b0;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 32'h8000_0000);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    sbq.delete();
    acc = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // First four outputs after reset are transients and go unchecked.
  task automatic run(input int mode, input int nf, input logic [31:0] d,
                     input logic s, input logic [31:0] tol);
    for (int f = 0; f < nf; f++) begin
      sbq.push_back('{chk: (f >= 4), d: d, s: s, tol: tol});
      for (int i = 0; i < R; i++)
        tick(gen_bit(mode, i));
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    sdi = 1'b0;
    ock = 1'b0;
    do_reset();

    run(1, 10, 32'hFFFF_FFFF, 1'b1, 32'd0);
    chk("fs_pos_drain", 32'(sbq.size()), 32'd0);

    do_reset();
    run(0, 8, 32'h0000_0000, 1'b0, 32'd0);
    chk("fs_neg_drain", 32'(sbq.size()), 32'd0);

    do_reset();
    run(2, 8, 32'h8000_0000, 1'b0, 32'd0);

    // Latency: 2 sync flops + 2 pipeline stages from ock rise to valid.
    sbq.push_back('{chk: 1'b1, d: 32'h8000_0000, s: 1'b0, tol: 32'd0});
    for (int i = 0; i < R - 1; i++)
      tick(gen_bit(2, i));
    @(negedge clk);
    sdi = gen_bit(2, R - 1);
    ock = 1'b1;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (dout_valid) begin
        n = c;
        break;
      end
    end
    chk("latency", 32'(n), 32'd4);
    @(posedge clk);
    #1;
    chk("valid_width", 32'(dout_valid), 32'd0);
    repeat (HALF - 5) @(negedge clk);
    ock = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("alt_drain", 32'(sbq.size()), 32'd0);

    do_reset();
    run(3, 8, 32'hC000_0000, 1'b0, 32'h0001_0000);
    chk("mod_drain", 32'(sbq.size()), 32'd0);

    do_reset();
    run(1, 5, 32'hFFFF_FFFF, 1'b1, 32'd0);
    for (int i = 0; i < 30; i++)
      tick(1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_dout", dout, 32'h8000_0000);
    chk("midrst_valid", 32'(dout_valid), 32'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sbq.push_back('{chk: 1'b0, d: 32'h0, s: 1'b0, tol: 32'd0});
    for (int i = 0; i < R - 1; i++)
      tick(1'b1);
    repeat (6) @(negedge clk);
    chk("midrst_no_early", 32'(sbq.size()), 32'd1);
    tick(1'b1);
    chk("midrst_one_out", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
